adsr_voice: RTL
===============

# adsr_voice

Single-voice ADSR envelope generator with integrated output amplifier for the audio subsystem. Replaces the two-stage attack/release voice path with a four-stage attack/decay/sustain/release envelope, parametrised sample and volume widths, gate retrigger, stage status and an end-of-note strobe. One instance sits per synth voice between the oscillator output and the mixer, advancing once per `sample_clock`.

## Interface
- `BITDEPTH`, 14: sample width, signed two's complement, on `in` and `out`.
- `ENV_BITS`, 8: volume width and sustain-level width.
- `sample_clock` input 1: sole clock, one edge per audio sample.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in` input BITDEPTH: signed input sample.
- `gate` input 1: note on while high.
- `attack_rate` input 8: level increment per edge in ATTACK.
- `decay_rate` input 8: level decrement per edge in DECAY.
- `sustain_level` input ENV_BITS: sustain volume.
- `release_rate` input 8: level decrement per edge in RELEASE.
- `out` output BITDEPTH: signed, scaled sample, registered.
- `volume` output ENV_BITS: current envelope volume.
- `stage` output 3: current stage code.
- `done` output 1: one-cycle pulse when RELEASE reaches zero.

## Operation
- Level register `L`: ENV_BITS+8 bits (8 fractional bits). `LMAX` is all ones. `volume = L[top ENV_BITS]`. Sustain target `T = {sustain_level, 8'h00}`.
- `gate_q` holds the registered `gate`. Rise = `gate & ~gate_q`.
- Priority at each edge: rise, then gate-low, then stage rule.
- Rise, from any stage: stage becomes ATTACK and `L` is unchanged, so a retrigger resumes from the current level.
- `gate` low while in ATTACK, DECAY or SUSTAIN: stage becomes RELEASE and `L` is unchanged.
- IDLE: `L`=0.
- ATTACK: `L+attack_rate`. On carry or a result equal to `LMAX`: `L=LMAX`, then DECAY.
- DECAY: `L-decay_rate`. On underflow or a result ≤ `T`: `L=T`, then SUSTAIN.
- SUSTAIN: `L=T` on every edge. This tracks live `sustain_level` changes.
- RELEASE: if `L==0`, or `release_rate≠0` and `L≤release_rate`: `L=0`, stage becomes IDLE, `done`=1 for one cycle. Otherwise `L-release_rate`.
- A rate of 0 holds `L` in that stage indefinitely. Exception: RELEASE with `L==0` completes.
- `sustain_level=0`: DECAY ends at 0 and stays in SUSTAIN until the gate falls. RELEASE then completes on the next edge.
- Amplifier: `out <= (in * volume) >>> ENV_BITS`. Signed multiply, full-width product, arithmetic shift, truncate to BITDEPTH. The result cannot overflow.

## Timing
- Reset: `L`=0, stage=IDLE(0), `gate_q`=0, `out`=0, `volume`=0, `done`=0.
- If `gate` is already high when reset releases, it is seen as a rise at the first edge.
- Stage change occurs at the edge that samples the condition. The first ATTACK increment is at the edge after the rise.
- `volume` and `stage` are combinational from registers and change at the same edge as `L`.
- `out` latency is 1 edge from `in` and the current `volume`.
- `done` is high for exactly the cycle in which stage reads IDLE after RELEASE. It is never asserted on reset.

## Configuration
- `ADSR_EXP_RELEASE_EN` defined: in DECAY and RELEASE the step is `((L - target) >> 6) + rate`, with target `T` or 0, giving an exponential-like curve. Rate 0 still holds. End conditions are unchanged.
- `ADSR_EXP_RELEASE_EN` undefined: all stages are linear, as above.

## Structure
- Package `adsr_pkg`:
  - stage enum: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4;
  - `FRAC_BITS=8`;
  - `EXP_SHIFT=6`.
- Sub-module `voice_amp`: the registered signed scaler, parametrised by BITDEPTH and ENV_BITS. Everything else lives in `adsr_voice`.

## Test plan
All scenarios use BITDEPTH=14, ENV_BITS=8.
- Reset mid-note: with stage=SUSTAIN, assert `rst_n`=0 → `out`, `volume`, `stage` and `done` are all 0 immediately, without waiting for a clock edge.
- Attack: `attack_rate`=0xFF, rise gate → `L` reaches 0xFFFF on the 257th increment edge, stage=DECAY, `volume`=0xFF.
- Decay: `decay_rate`=0x80, `sustain_level`=0x80 → SUSTAIN after 256 edges, `L`=0x8000. Changing sustain to 0x40 → `L`=0x4000 at the next edge.
- Release: from `L`=0x8000, `release_rate`=0x10, gate low → IDLE after 2048 edges, `done` high for exactly one cycle.
- Retrigger: gate low for 100 edges in RELEASE, then a rise → ATTACK resumes from the current `L`, not from 0.
- Amplifier:
  - `in`=0x1FFF, `volume`=0x80 → `out`=0x0FFF after one edge;
  - `in`=0x2000, `volume`=0xFF → `out`=0x2020 (-8160).

Source files
------------

// File: rtl/adsr_voice_pkg.sv
// Shared types and constants for the ADSR voice: stage encoding and level fixed-point layout.
package adsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } stage_e;

  localparam int FRAC_BITS = 8;
  localparam int EXP_SHIFT = 6;

endpackage

// File: rtl/adsr_voice_if.sv
// Voice control/sample bundle between the voice controller (master) and adsr_voice (slave).
interface adsr_voice_if #(
  parameter int BITDEPTH = 14,
  parameter int ENV_BITS = 8
);
  logic signed [BITDEPTH-1:0] in;
  logic                       gate;
  logic [7:0]                 attack_rate;
  logic [7:0]                 decay_rate;
  logic [ENV_BITS-1:0]        sustain_level;
  logic [7:0]                 release_rate;
  logic signed [BITDEPTH-1:0] out;
  logic [ENV_BITS-1:0]        volume;
  logic [2:0]                 stage;
  logic                       done;

  modport master (
    output in, gate, attack_rate, decay_rate, sustain_level, release_rate,
    input  out, volume, stage, done
  );

  modport slave (
    input  in, gate, attack_rate, decay_rate, sustain_level, release_rate,
    output out, volume, stage, done
  );
endinterface

// File: rtl/adsr_voice_amp.sv
// voice_amp: registered signed scaler, out = (sample * gain) >>> ENV_BITS with gain unsigned.
module voice_amp #(
  parameter int BITDEPTH = 14,
  parameter int ENV_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [BITDEPTH-1:0] sample,
  input  logic [ENV_BITS-1:0]        gain,
  output logic signed [BITDEPTH-1:0] scaled
);
  localparam int PW = BITDEPTH + ENV_BITS + 1;

  logic signed [PW-1:0] product_s;
  logic                 unused_s;

  // Both operands widened to the full product width; gain is zero-extended so it stays positive.
  assign product_s = $signed({{(ENV_BITS + 1){sample[BITDEPTH-1]}}, sample})
                   * $signed({{BITDEPTH{1'b0}}, gain});

  // Gain never exceeds 1.0, so only the fractional bits and the spare sign bit are discarded.
  assign unused_s = ^{product_s[PW-1], product_s[ENV_BITS-1:0]};

  // Output register: arithmetic shift realised as a slice of the signed product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled <= {BITDEPTH{1'b0}};
    end else begin
      scaled <= product_s[BITDEPTH+ENV_BITS-1:ENV_BITS];
    end
  end
endmodule

// File: rtl/adsr_voice.sv
// Single-voice ADSR envelope with output amplifier; one step per sample_clock edge.
// Define ADSR_EXP_RELEASE_EN for exponential-like DECAY/RELEASE steps (default: linear).
module adsr_voice
  import adsr_pkg::*;
#(
  parameter int BITDEPTH = 14,
  parameter int ENV_BITS = 8
) (
  input  logic         sample_clock,
  input  logic         rst_n,
  adsr_voice_if.slave  bus
);
  localparam int LW   = ENV_BITS + FRAC_BITS;
  localparam int RPAD = LW + 1 - 8;
  localparam logic [LW-1:0] LMAX = {LW{1'b1}};

  logic [LW-1:0] level_r;
  logic [LW-1:0] level_s;
  stage_e        stage_r;
  stage_e        stage_s;
  logic          gate_q_r;
  logic          done_r;
  logic          done_s;
  logic          rise_s;
  logic [LW-1:0] target_s;
  logic [LW:0]   sum_s;
  logic [LW:0]   dstep_s;
  logic [LW:0]   rstep_s;
  logic [LW:0]   ddiff_s;
  logic [LW:0]   rdiff_s;
  logic [ENV_BITS-1:0] volume_s;

  assign rise_s   = bus.gate & ~gate_q_r;
  assign target_s = {bus.sustain_level, {FRAC_BITS{1'b0}}};
  assign volume_s = level_r[LW-1 -: ENV_BITS];

`ifdef ADSR_EXP_RELEASE_EN
  // Step grows with the distance to the target, giving a curve that slows as it approaches it.
  always_comb begin
    if (level_r > target_s) begin
      dstep_s = ({1'b0, level_r - target_s} >> EXP_SHIFT) + {{RPAD{1'b0}}, bus.decay_rate};
    end else begin
      dstep_s = {{RPAD{1'b0}}, bus.decay_rate};
    end
    rstep_s = ({1'b0, level_r} >> EXP_SHIFT) + {{RPAD{1'b0}}, bus.release_rate};
  end
`else
  assign dstep_s = {{RPAD{1'b0}}, bus.decay_rate};
  assign rstep_s = {{RPAD{1'b0}}, bus.release_rate};
`endif

  assign sum_s   = {1'b0, level_r} + {{RPAD{1'b0}}, bus.attack_rate};
  assign ddiff_s = {1'b0, level_r} - dstep_s;
  assign rdiff_s = {1'b0, level_r} - rstep_s;

  // Next-state logic: rise beats gate-low, which beats the per-stage level rule.
  always_comb begin
    level_s = level_r;
    stage_s = stage_r;
    done_s  = 1'b0;
    if (rise_s) begin
      stage_s = ATTACK;
    end else if (!bus.gate && (stage_r == ATTACK || stage_r == DECAY || stage_r == SUSTAIN)) begin
      stage_s = RELEASE;
    end else begin
      case (stage_r)
        IDLE: begin
          level_s = {LW{1'b0}};
        end
        ATTACK: begin
          if (bus.attack_rate == 8'd0) begin
            level_s = level_r;
          end else if (sum_s[LW] || sum_s[LW-1:0] == LMAX) begin
            level_s = LMAX;
            stage_s = DECAY;
          end else begin
            level_s = sum_s[LW-1:0];
          end
        end
        DECAY: begin
          if (bus.decay_rate == 8'd0) begin
            level_s = level_r;
          end else if (ddiff_s[LW] || ddiff_s[LW-1:0] <= target_s) begin
            level_s = target_s;
            stage_s = SUSTAIN;
          end else begin
            level_s = ddiff_s[LW-1:0];
          end
        end
        SUSTAIN: begin
          level_s = target_s;
        end
        RELEASE: begin
          // A zero level always completes, even when the rate would otherwise hold.
          if (level_r == {LW{1'b0}} ||
              (bus.release_rate != 8'd0 && level_r <= {{(LW-8){1'b0}}, bus.release_rate})) begin
            level_s = {LW{1'b0}};
            stage_s = IDLE;
            done_s  = 1'b1;
          end else if (bus.release_rate == 8'd0) begin
            level_s = level_r;
          end else if (rdiff_s[LW]) begin
            level_s = {LW{1'b0}};
          end else begin
            level_s = rdiff_s[LW-1:0];
          end
        end
        default: begin
          level_s = {LW{1'b0}};
          stage_s = IDLE;
        end
      endcase
    end
  end

  // Envelope state registers.
  always_ff @(posedge sample_clock or negedge rst_n) begin
    if (!rst_n) begin
      level_r  <= {LW{1'b0}};
      stage_r  <= IDLE;
      gate_q_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      level_r  <= level_s;
      stage_r  <= stage_s;
      gate_q_r <= bus.gate;
      done_r   <= done_s;
    end
  end

  assign bus.volume = volume_s;
  assign bus.stage  = stage_r;
  assign bus.done   = done_r;

  voice_amp #(
    .BITDEPTH (BITDEPTH),
    .ENV_BITS (ENV_BITS)
  ) u_amp (
    .clk    (sample_clock),
    .rst_n  (rst_n),
    .sample (bus.in),
    .gain   (volume_s),
    .scaled (bus.out)
  );
endmodule
